// File: rtl/circular_dma_pkg.sv
// ============================================================================
// Module : circular_dma_pkg
// Brief  : Types and constants shared by the circular MM2S/S2MM DMA cores.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package circular_dma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } dma_state_t;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  BURST_INCR  = 2'b01;
    localparam int unsigned BOUNDARY_4K = 4096;

    // Beat size is always a power of two between 1 and 128 bytes.
    function automatic int unsigned beat_log2(input int unsigned bytes);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 8; i++) begin
            if ((32'd1 << i) == bytes) begin
                r = i;
            end
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/circular_dma_reader_len.sv
// ============================================================================
// Module : circular_dma_reader_len
// Brief  : Combinational burst-length calculator for the circular reader.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module circular_dma_reader_len
    import circular_dma_pkg::*;
#(
    parameter int C_AXIS_WIDTH = 64,
    parameter int C_MAX_BURST  = 16
) (
    input  logic [31:0] i_rd_ptr,
    input  logic [31:0] i_wr_ptr,
    input  logic [31:0] i_cfg_size,
    input  logic [11:0] i_addr_lo,
    output logic        o_nonempty,
    output logic [8:0]  o_len
);

    localparam int unsigned LOG2B = beat_log2(C_AXIS_WIDTH / 8);

    logic [31:0] w_avail;
    logic [31:0] w_avail_beats;
    logic [31:0] w_wrap_beats;
    logic [31:0] w_4k_beats;
    logic [31:0] w_min_a;
    logic [31:0] w_min_b;
    logic [31:0] w_min;

    // Equal pointers mean empty; the producer never fills the last beat.
    assign w_avail = (i_wr_ptr >= i_rd_ptr) ? (i_wr_ptr - i_rd_ptr)
                                            : (i_cfg_size - i_rd_ptr + i_wr_ptr);

    assign w_avail_beats = w_avail >> LOG2B;
    assign w_wrap_beats  = (i_cfg_size - i_rd_ptr) >> LOG2B;
    assign w_4k_beats    = (32'(BOUNDARY_4K) - {20'd0, i_addr_lo}) >> LOG2B;

    assign w_min_a = (w_avail_beats < w_wrap_beats) ? w_avail_beats : w_wrap_beats;
    assign w_min_b = (w_4k_beats < 32'(C_MAX_BURST)) ? w_4k_beats : 32'(C_MAX_BURST);
    assign w_min   = (w_min_a < w_min_b) ? w_min_a : w_min_b;

    assign o_nonempty = (w_avail != 32'd0);
    assign o_len      = (|w_min[31:9]) ? 9'd256 : w_min[8:0];

endmodule

`default_nettype wire

// File: rtl/circular_dma_reader.sv
// ============================================================================
// Module : circular_dma_reader
// Brief  : Drains a circular memory buffer over AXI4 read into an AXI-Stream.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module circular_dma_reader
    import circular_dma_pkg::*;
#(
    parameter int C_ADDR_WIDTH = 32,
    parameter int C_AXIS_WIDTH = 64,
    parameter int C_MAX_BURST  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cfg_enable,
    input  logic [C_ADDR_WIDTH-1:0]   cfg_base,
    input  logic [31:0]               cfg_size,
    input  logic [31:0]               wr_ptr,
    output logic [31:0]               rd_ptr,
    output logic                      busy,
    output logic                      error,
    output logic                      irq,
    output logic [C_ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [7:0]                m_axi_arlen,
    output logic [2:0]                m_axi_arsize,
    output logic [1:0]                m_axi_arburst,
    output logic [2:0]                m_axi_arprot,
    output logic [3:0]                m_axi_arcache,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    input  logic [C_AXIS_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rlast,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready,
    output logic [C_AXIS_WIDTH-1:0]   m_axis_mm2s_tdata,
    output logic                      m_axis_mm2s_tlast,
    output logic                      m_axis_mm2s_tvalid,
    input  logic                      m_axis_mm2s_tready
);

    localparam int unsigned BEAT_BYTES = C_AXIS_WIDTH / 8;
    localparam int unsigned LOG2B      = beat_log2(BEAT_BYTES);

    dma_state_t                r_state;
    dma_state_t                w_next_state;
    logic [31:0]               r_rd_ptr;
    logic                      r_error;
    logic                      r_irq;
    logic [C_ADDR_WIDTH-1:0]   r_araddr;
    logic [7:0]                r_arlen;
    logic                      r_arvalid;
    logic                      r_tlast_en;

    logic [C_ADDR_WIDTH-1:0]   w_addr;
    logic                      w_nonempty;
    logic [8:0]                w_len;
    logic [31:0]               w_post;
    logic [31:0]               w_post_wrapped;
    logic [31:0]               w_rd_inc;
    logic [31:0]               w_rd_next;
    logic                      w_start;
    logic                      w_beat;
    logic                      w_last_hs;

    assign w_addr = cfg_base + C_ADDR_WIDTH'(r_rd_ptr);

    circular_dma_reader_len #(
        .C_AXIS_WIDTH (C_AXIS_WIDTH),
        .C_MAX_BURST  (C_MAX_BURST)
    ) u_len (
        .i_rd_ptr   (r_rd_ptr),
        .i_wr_ptr   (wr_ptr),
        .i_cfg_size (cfg_size),
        .i_addr_lo  (w_addr[11:0]),
        .o_nonempty (w_nonempty),
        .o_len      (w_len)
    );

    // Bursts never cross the wrap point, so the end offset needs one compare.
    assign w_post         = r_rd_ptr + (32'(w_len) << LOG2B);
    assign w_post_wrapped = (w_post == cfg_size) ? 32'd0 : w_post;

    assign w_rd_inc  = r_rd_ptr + 32'(BEAT_BYTES);
    assign w_rd_next = (w_rd_inc == cfg_size) ? 32'd0 : w_rd_inc;

    assign w_start   = (r_state == ST_IDLE) && cfg_enable && !r_error && w_nonempty;
    assign w_beat    = (r_state == ST_DATA) && m_axi_rvalid && m_axis_mm2s_tready;
    assign w_last_hs = w_beat && m_axi_rlast;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state       = r_state;
        busy               = (r_state != ST_IDLE);
        m_axi_rready       = 1'b0;
        m_axis_mm2s_tvalid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_next_state = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (r_arvalid && m_axi_arready) begin
                    w_next_state = ST_DATA;
                end
            end
            ST_DATA: begin
                m_axi_rready       = m_axis_mm2s_tready;
                m_axis_mm2s_tvalid = m_axi_rvalid;
                if (w_last_hs) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr   <= 32'd0;
            r_error    <= 1'b0;
            r_irq      <= 1'b0;
            r_araddr   <= '0;
            r_arlen    <= 8'd0;
            r_arvalid  <= 1'b0;
            r_tlast_en <= 1'b0;
        end else begin
            r_irq <= 1'b0;
            if (w_start) begin
                r_araddr   <= w_addr;
                r_arlen    <= 8'(w_len - 9'd1);
                r_arvalid  <= 1'b1;
                r_tlast_en <= (w_post_wrapped == wr_ptr);
            end
            if (r_arvalid && m_axi_arready) begin
                r_arvalid <= 1'b0;
            end
            if (w_beat) begin
                r_rd_ptr <= w_rd_next;
                if (m_axi_rresp != RESP_OKAY) begin
                    r_error <= 1'b1;
                end
                if (m_axi_rlast && (w_rd_next == wr_ptr)) begin
                    r_irq <= 1'b1;
                end
            end
            // Disabling in IDLE rewinds the consumer and re-arms after an error.
            if ((r_state == ST_IDLE) && !cfg_enable) begin
                r_rd_ptr <= 32'd0;
                r_error  <= 1'b0;
            end
        end
    end

    assign rd_ptr = r_rd_ptr;
    assign error  = r_error;
    assign irq    = r_irq;

    assign m_axi_araddr  = r_araddr;
    assign m_axi_arlen   = r_arlen;
    assign m_axi_arvalid = r_arvalid;
    assign m_axi_arsize  = 3'(LOG2B);
    assign m_axi_arburst = BURST_INCR;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arcache = 4'b0011;

    assign m_axis_mm2s_tdata = m_axi_rdata;
    assign m_axis_mm2s_tlast = m_axi_rlast && r_tlast_en;

endmodule

`default_nettype wire

// File: tb/tb_circular_dma_reader.sv
// ============================================================================
// Module : tb_circular_dma_reader
// Brief  : Scoreboard bench for circular_dma_reader with an AXI read slave.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_circular_dma_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_enable;
    logic [31:0] cfg_base;
    logic [31:0] cfg_size;
    logic [31:0] wr_ptr;
    logic [31:0] rd_ptr;
    logic        busy, error, irq;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [2:0]  arprot;
    logic [3:0]  arcache;
    logic        arvalid, arready;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;
    logic [63:0] tdata;
    logic        tlast, tvalid, tready;

    always #5 clk = ~clk;

    circular_dma_reader #(
        .C_ADDR_WIDTH (32),
        .C_AXIS_WIDTH (64),
        .C_MAX_BURST  (16)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .cfg_enable         (cfg_enable),
        .cfg_base           (cfg_base),
        .cfg_size           (cfg_size),
        .wr_ptr             (wr_ptr),
        .rd_ptr             (rd_ptr),
        .busy               (busy),
        .error              (error),
        .irq                (irq),
        .m_axi_araddr       (araddr),
        .m_axi_arlen        (arlen),
        .m_axi_arsize       (arsize),
        .m_axi_arburst      (arburst),
        .m_axi_arprot       (arprot),
        .m_axi_arcache      (arcache),
        .m_axi_arvalid      (arvalid),
        .m_axi_arready      (arready),
        .m_axi_rdata        (rdata),
        .m_axi_rresp        (rresp),
        .m_axi_rlast        (rlast),
        .m_axi_rvalid       (rvalid),
        .m_axi_rready       (rready),
        .m_axis_mm2s_tdata  (tdata),
        .m_axis_mm2s_tlast  (tlast),
        .m_axis_mm2s_tvalid (tvalid),
        .m_axis_mm2s_tready (tready)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
    } ar_t;

    typedef struct packed {
        logic [63:0] d;
        logic        l;
    } beat_t;

    ar_t   exp_ar[$];
    beat_t exp_b[$];

    int checks = 0;
    int errors = 0;
    int irq_cnt = 0;
    int beats_seen = 0;
    int ar_cnt = 0;
    int ar_delay = 0;
    int err_beat = -1;
    logic tr_toggle = 1'b0;

    function automatic logic [63:0] mem_word(input logic [31:0] a);
        return {a ^ 32'hA5A5_5A5A, a};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic push_burst(input logic [31:0] addr, input int beats, input logic final_last);
        ar_t a;
        beat_t b;
        a.addr = addr;
        a.len  = 8'(beats - 1);
        exp_ar.push_back(a);
        for (int i = 0; i < beats; i++) begin
            b.d = mem_word(addr + 32'(i * 8));
            b.l = final_last && (i == beats - 1);
            exp_b.push_back(b);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_done(input int budget, input string name);
        int i;
        for (i = 0; i < budget; i++) begin
            @(posedge clk);
            #2;
            if (exp_b.size() == 0 && exp_ar.size() == 0 && !busy) break;
        end
        checks++;
        if (i == budget) begin
            errors++;
            $display("FAIL %s_timeout actual=%0d beats pending required=0", name, exp_b.size());
        end
        cycles(3);
    endtask

    // Handshakes are sampled mid-cycle so the slave acts on the edge they occur.
    logic        ar_hs = 1'b0, r_hs = 1'b0;
    logic        p_pend = 1'b0;
    logic [31:0] p_addr;
    logic [7:0]  p_len;

    always @(negedge clk) begin
        beat_t e;
        ar_hs = arvalid && arready;
        r_hs  = rvalid && rready;
        if (rst_n) begin
            if (p_pend) begin
                checks++;
                if (!arvalid || araddr != p_addr || arlen != p_len) begin
                    errors++;
                    $display("FAIL ar_stable actual=%0h/%0d/%0b required=%0h/%0d/1",
                             araddr, arlen, arvalid, p_addr, p_len);
                end
            end
            p_pend = arvalid && !arready;
            p_addr = araddr;
            p_len  = arlen;
            if (rvalid) chk("rready_eq_tready", 64'(rready), 64'(tready));
            if (tvalid && tready) begin
                beats_seen++;
                if (exp_b.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat actual=%0h required=none", tdata);
                end else begin
                    e = exp_b.pop_front();
                    chk("tdata", tdata, e.d);
                    chk("tlast", 64'(tlast), 64'(e.l));
                end
            end
            if (irq) irq_cnt++;
        end else begin
            p_pend = 1'b0;
        end
    end

    int          s_st = 0, s_wait = 0, s_beat = 0;
    logic [31:0] s_addr;
    logic [7:0]  s_len;

    task automatic drive_beat();
        rvalid = 1'b1;
        rdata  = mem_word(s_addr + 32'(s_beat * 8));
        rlast  = (s_beat == int'(s_len));
        rresp  = (s_beat == err_beat) ? 2'b10 : 2'b00;
    endtask

    initial begin
        ar_t a;
        arready = 1'b0;
        rvalid  = 1'b0;
        rdata   = 64'd0;
        rresp   = 2'b00;
        rlast   = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                s_st    = 0;
                arready = 1'b0;
                rvalid  = 1'b0;
                rlast   = 1'b0;
            end else begin
                case (s_st)
                    0: if (arvalid) begin
                        ar_cnt++;
                        if (exp_ar.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_ar actual=%0h/%0d required=none", araddr, arlen);
                        end else begin
                            a = exp_ar.pop_front();
                            chk("araddr", 64'(araddr), 64'(a.addr));
                            chk("arlen", 64'(arlen), 64'(a.len));
                        end
                        s_addr  = araddr;
                        s_len   = arlen;
                        s_wait  = ar_delay;
                        arready = (s_wait == 0);
                        s_st    = 1;
                    end
                    1: if (ar_hs) begin
                        arready = 1'b0;
                        s_beat  = 0;
                        drive_beat();
                        s_st    = 2;
                    end else begin
                        if (s_wait > 0) s_wait--;
                        arready = (s_wait == 0);
                    end
                    2: if (r_hs) begin
                        if (s_beat == int'(s_len)) begin
                            rvalid = 1'b0;
                            rlast  = 1'b0;
                            s_st   = 0;
                        end else begin
                            s_beat++;
                            drive_beat();
                        end
                    end
                    default: s_st = 0;
                endcase
            end
        end
    end

    initial begin
        tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            tready = tr_toggle ? ~tready : 1'b1;
        end
    end

    initial begin
        int n;
        int beats0;
        cfg_enable = 1'b0;
        cfg_base   = 32'h1000_0000;
        cfg_size   = 32'h400;
        wr_ptr     = 32'h0;
        rst_n      = 1'b0;
        cycles(3);
        chk("rst_rd_ptr", 64'(rd_ptr), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_error", 64'(error), 64'h0);
        chk("rst_irq", 64'(irq), 64'h0);
        chk("rst_arvalid", 64'(arvalid), 64'h0);
        chk("rst_rready", 64'(rready), 64'h0);
        chk("rst_tvalid", 64'(tvalid), 64'h0);
        chk("arsize", 64'(arsize), 64'h3);
        chk("arburst", 64'(arburst), 64'h1);
        rst_n = 1'b1;
        cycles(2);

        // Single 8-beat burst from the base.
        push_burst(32'h1000_0000, 8, 1'b1);
        irq_cnt    = 0;
        wr_ptr     = 32'h40;
        cfg_enable = 1'b1;
        wait_done(500, "t1");
        chk("t1_rd_ptr", 64'(rd_ptr), 64'h40);
        chk("t1_irq", 64'(irq_cnt), 64'd1);

        // Advance to 0x3C0 with seven max-length bursts.
        for (int k = 0; k < 7; k++) begin
            push_burst(32'h1000_0040 + 32'(k * 32'h80), 16, k == 6);
        end
        irq_cnt = 0;
        wr_ptr  = 32'h3C0;
        wait_done(2000, "fill");
        chk("fill_rd_ptr", 64'(rd_ptr), 64'h3C0);
        chk("fill_irq", 64'(irq_cnt), 64'd1);

        // Wrap: 8 beats to the end, then 16 from the base.
        push_burst(32'h1000_03C0, 8, 1'b0);
        push_burst(32'h1000_0000, 16, 1'b1);
        irq_cnt = 0;
        wr_ptr  = 32'h80;
        wait_done(1000, "wrap");
        chk("wrap_rd_ptr", 64'(rd_ptr), 64'h80);
        chk("wrap_irq", 64'(irq_cnt), 64'd1);

        // 4 KiB clamp with delayed arready and toggling tready.
        cfg_enable = 1'b0;
        cycles(2);
        chk("dis_rd_ptr", 64'(rd_ptr), 64'h0);
        cfg_base  = 32'h1000_0FE0;
        wr_ptr    = 32'h100;
        ar_delay  = 5;
        tr_toggle = 1'b1;
        push_burst(32'h1000_0FE0, 4, 1'b0);
        push_burst(32'h1000_1000, 16, 1'b0);
        push_burst(32'h1000_1080, 12, 1'b1);
        irq_cnt    = 0;
        cfg_enable = 1'b1;
        wait_done(2000, "b4k");
        chk("b4k_rd_ptr", 64'(rd_ptr), 64'h100);
        chk("b4k_irq", 64'(irq_cnt), 64'd1);
        ar_delay  = 0;
        tr_toggle = 1'b0;

        // SLVERR on beat 3: burst completes, then no further bursts.
        cfg_enable = 1'b0;
        cycles(2);
        cfg_base = 32'h1000_0000;
        wr_ptr   = 32'h40;
        err_beat = 2;
        push_burst(32'h1000_0000, 8, 1'b1);
        irq_cnt    = 0;
        cfg_enable = 1'b1;
        wait_done(500, "err");
        chk("err_flag", 64'(error), 64'h1);
        chk("err_rd_ptr", 64'(rd_ptr), 64'h40);
        chk("err_irq", 64'(irq_cnt), 64'd1);
        err_beat = -1;
        n        = ar_cnt;
        wr_ptr   = 32'h80;
        cycles(20);
        chk("err_no_ar", 64'(ar_cnt), 64'(n));
        chk("err_busy", 64'(busy), 64'h0);
        chk("err_sticky", 64'(error), 64'h1);
        cfg_enable = 1'b0;
        cycles(2);
        chk("err_cleared", 64'(error), 64'h0);
        chk("err_rd_ptr0", 64'(rd_ptr), 64'h0);

        // Asynchronous reset in the middle of a data phase.
        push_burst(32'h1000_0000, 16, 1'b1);
        beats0     = beats_seen;
        cfg_enable = 1'b1;
        for (int i = 0; i < 200 && beats_seen < beats0 + 3; i++) @(posedge clk);
        chk("mid_beats_reached", 64'(beats_seen >= beats0 + 3), 64'h1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_rd_ptr", 64'(rd_ptr), 64'h0);
        chk("arst_busy", 64'(busy), 64'h0);
        chk("arst_rready", 64'(rready), 64'h0);
        chk("arst_tvalid", 64'(tvalid), 64'h0);
        chk("arst_arvalid", 64'(arvalid), 64'h0);
        chk("arst_irq", 64'(irq), 64'h0);
        cfg_enable = 1'b0;
        exp_b.delete();
        exp_ar.delete();
        cycles(2);
        rst_n = 1'b1;
        cycles(5);
        chk("post_rst_busy", 64'(busy), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
